// File: rtl/gray_stream_pkg.sv
// Shared types and helpers for the binary/Gray stream converter.
// Payload words are carried MAX_W wide; the converter uses the low WIDTH bits.
package gray_stream_pkg;
   localparam int MAX_W = 64;
   localparam int PC_W  = $clog2(MAX_W + 1);

   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   // partial is the running prefix-XOR carried out of the last resolved slice
   typedef struct packed {
      logic [MAX_W-1:0] data;
      logic             mode;
      logic             err;
      logic             partial;
   } stage_pl_t;

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PC_W-1:0] popcount(input logic [MAX_W-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_W; i++) n = n + PC_W'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/gray_stream_converter_stage.sv
// One pipeline register with valid/ready; in Gray->binary mode it resolves
// bits HI..LO of the prefix-XOR using the carry from the stage above.
module gray_pipe_stage
   import gray_stream_pkg::*;
#(
   parameter int HI = 0,
   parameter int LO = 0
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      in_valid,
   output logic      in_ready,
   input  stage_pl_t in_pl,
   output logic      out_valid,
   input  logic      out_ready,
   output stage_pl_t out_pl
);
   logic      vld_q, vld_d, load;
   stage_pl_t pl_q, pl_d, conv;

   always_comb begin
      conv = in_pl;
      if (in_pl.mode == MODE_G2B) begin
         for (int i = HI; i >= LO; i--) begin
            conv.partial = conv.partial ^ in_pl.data[i];
            conv.data[i] = conv.partial;
         end
      end
   end

   assign load     = !vld_q || out_ready;
   assign in_ready = load;

   always_comb begin
      vld_d = load ? in_valid : vld_q;
      pl_d  = (load && in_valid) ? conv : pl_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         pl_q  <= '0;
      end else begin
         vld_q <= vld_d;
         pl_q  <= pl_d;
      end
   end

   assign out_valid = vld_q;
   assign out_pl    = pl_q;
endmodule

// File: rtl/gray_stream_converter.sv
// Pipelined binary<->Gray converter with valid/ready streams and a
// Gray-adjacency checker for CDC pointer streams (WIDTH up to 63).
module gray_stream_converter
   import gray_stream_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int STAGES    = 2,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_mode,
   output logic                 out_adj_err,
   output logic [ERR_CNT_W-1:0] err_count
);
   localparam int SL = (WIDTH + STAGES - 1) / STAGES;

   wire [STAGES:0] vld_pipe, rdy_pipe;
   wire stage_pl_t pl_pipe [STAGES+1];

   stage_pl_t            st0_pl;
   logic                 in_xfer, adj_err;
   logic [WIDTH-1:0]     prev_gray_q, prev_gray_d;
   logic                 prev_vld_q, prev_vld_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 unused_bits;

   assign in_ready     = rdy_pipe[0] && !rst;
   assign in_xfer      = in_valid && in_ready;
   assign vld_pipe[0]  = in_valid && !rst;
   assign rdy_pipe[STAGES] = out_ready;
   assign pl_pipe[0]   = st0_pl;

   always_comb begin
      adj_err = (in_mode == MODE_G2B) && prev_vld_q &&
                (popcount(MAX_W'(in_data ^ prev_gray_q)) > PC_W'(1));
      st0_pl      = '0;
      st0_pl.mode = in_mode;
      st0_pl.err  = adj_err;
      st0_pl.data = (in_mode == MODE_B2G) ? bin2gray(MAX_W'(in_data)) : MAX_W'(in_data);
   end

   // A binary word breaks the Gray history, so the next Gray word is unchecked
   always_comb begin
      prev_gray_d = prev_gray_q;
      prev_vld_d  = prev_vld_q;
      if (in_xfer) begin
         if (in_mode == MODE_G2B) begin
            prev_gray_d = in_data;
            prev_vld_d  = 1'b1;
         end else begin
            prev_vld_d  = 1'b0;
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int HI = WIDTH - 1 - k * SL;
      localparam int LO = (HI - SL + 1 < 0) ? 0 : HI - SL + 1;
      gray_pipe_stage #(.HI(HI), .LO(LO)) u_stage (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (vld_pipe[k]),
         .in_ready  (rdy_pipe[k]),
         .in_pl     (pl_pipe[k]),
         .out_valid (vld_pipe[k+1]),
         .out_ready (rdy_pipe[k+1]),
         .out_pl    (pl_pipe[k+1])
      );
   end

   assign out_valid   = vld_pipe[STAGES] && !rst;
   assign out_data    = pl_pipe[STAGES].data[WIDTH-1:0];
   assign out_mode    = pl_pipe[STAGES].mode;
   assign out_adj_err = pl_pipe[STAGES].err;
   assign unused_bits = ^{pl_pipe[STAGES].data[MAX_W-1:WIDTH], pl_pipe[STAGES].partial};

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (out_valid && out_ready && out_adj_err && !(&err_cnt_q))
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_gray_q <= '0;
         prev_vld_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         prev_gray_q <= prev_gray_d;
         prev_vld_q  <= prev_vld_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
endmodule

// File: tb/tb_gray_stream_converter.sv
// Directed bench: WIDTH=4 converters at STAGES 2 (main), 1 and 4 (ERR_CNT_W=2)
// sharing one input stream; outputs are logged and compared to hand tables.
module tb_gray_stream_converter;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
   logic [3:0] in_data = 4'h0;
   always #5 clk = ~clk;

   int checks = 0, failures = 0, cyc = 0;
   logic stalled = 1'b0;

   logic ir0, ov0, om0, oe0; logic [3:0] od0; logic [15:0] ec0;
   logic ir1, ov1, om1, oe1; logic [3:0] od1; logic [15:0] ec1;
   logic ir4, ov4, om4, oe4; logic [3:0] od4; logic [1:0]  ec4;

   gray_stream_converter #(.WIDTH(4), .STAGES(2), .ERR_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
      .out_mode(om0), .out_adj_err(oe0), .err_count(ec0));
   gray_stream_converter #(.WIDTH(4), .STAGES(1), .ERR_CNT_W(16)) dut_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .out_mode(om1), .out_adj_err(oe1), .err_count(ec1));
   gray_stream_converter #(.WIDTH(4), .STAGES(4), .ERR_CNT_W(2)) dut_s4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
      .in_mode(in_mode), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
      .out_mode(om4), .out_adj_err(oe4), .err_count(ec4));

   typedef struct { logic [3:0] d; logic m; logic e; int cyc; } rec_t;
   rec_t q0[$], q1[$], q4[$];
   int   in_cyc[$];
   int   gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic rec_t mk(input logic [3:0] d, input logic m, input logic e, input int c);
      rec_t r;
      r.d = d; r.m = m; r.e = e; r.cyc = c;
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && ov0 && out_ready) q0.push_back(mk(od0, om0, oe0, cyc));
      if (!rst && ov1 && out_ready) q1.push_back(mk(od1, om1, oe1, cyc));
      if (!rst && ov4 && out_ready) q4.push_back(mk(od4, om4, oe4, cyc));
      if (in_valid && ir0) in_cyc.push_back(cyc);
   end

   // Producer rule: a stalled word must not change before it is accepted
   logic       hold_v = 1'b0;
   logic [4:0] hold_d = 5'h0;
   always @(posedge clk) begin
      if (hold_v && in_valid) chk("in_hold", 32'({in_mode, in_data}), 32'(hold_d));
      hold_v <= in_valid && !ir0;
      hold_d <= {in_mode, in_data};
   end

   task automatic send(input logic m, input logic [3:0] d);
      int t;
      @(negedge clk);
      in_valid = 1'b1; in_mode = m; in_data = d;
      #4;
      t = 0;
      while (!ir0 && t < 40) begin
         @(negedge clk); #4; t++;
      end
      if (t == 40) chk("send_timeout", 32'(t), 0);
      if (t != 0) stalled = 1'b1;
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q0.delete(); q1.delete(); q4.delete(); in_cyc.delete();
   endtask

   task automatic wait_out(input int n);
      int t;
      t = 0;
      while ((q0.size() < n || q1.size() < n || q4.size() < n) && t < 100) begin
         @(negedge clk); t++;
      end
      repeat (3) @(negedge clk);
      chk("out_count", 32'(q0.size()), 32'(n));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int exp_d[6];
      int exp_e[4];
      repeat (2) @(negedge clk);

      // Reset state and a single binary->Gray word
      do_reset();
      #1;
      chk("rst_out_valid", 32'(ov0), 0);
      chk("rst_out_data", 32'(od0), 0);
      chk("rst_out_mode", 32'(om0), 0);
      chk("rst_out_err", 32'(oe0), 0);
      chk("rst_err_count", 32'(ec0), 0);
      send(1'b0, 4'b1011);
      idle();
      wait_out(1);
      chk("b2g_data", 32'(q0[0].d), 'hE);
      chk("b2g_mode", 32'(q0[0].m), 0);
      chk("b2g_err", 32'(q0[0].e), 0);
      chk("b2g_latency", 32'(q0[0].cyc - in_cyc[0]), 2);

      // Full-rate sweep, both modes; all three depths must agree
      do_reset();
      stalled = 1'b0;
      for (int i = 0; i < 16; i++) send(1'b0, 4'(i));
      for (int i = 0; i < 16; i++) send(1'b1, 4'(gtab[i]));
      idle();
      wait_out(32);
      chk("full_rate", 32'(stalled), 0);
      chk("g2b_1110", 32'(q0[16 + 11].d), 'hB);
      for (int i = 0; i < 32; i++) begin
         int e;
         e = (i < 16) ? gtab[i] : i - 16;
         chk($sformatf("sweep_s2_%0d", i), 32'(q0[i].d), 32'(e));
         chk($sformatf("sweep_s1_%0d", i), 32'(q1[i].d), 32'(e));
         chk($sformatf("sweep_s4_%0d", i), 32'(q4[i].d), 32'(e));
         chk($sformatf("sweep_mode_%0d", i), 32'(q0[i].m), (i < 16) ? 0 : 1);
         chk($sformatf("sweep_err_%0d", i), 32'(q0[i].e), 0);
         chk($sformatf("lat_s2_%0d", i), 32'(q0[i].cyc - in_cyc[i]), 2);
         chk($sformatf("lat_s1_%0d", i), 32'(q1[i].cyc - in_cyc[i]), 1);
         chk($sformatf("lat_s4_%0d", i), 32'(q4[i].cyc - in_cyc[i]), 4);
      end

      // Adjacency checking and history clearing by a binary word
      do_reset();
      send(1'b1, 4'b0011); send(1'b1, 4'b0010); send(1'b1, 4'b0110); send(1'b1, 4'b0101);
      idle();
      wait_out(4);
      exp_d = '{2, 3, 4, 6, 0, 0};
      exp_e = '{0, 0, 0, 1};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("adj_data_%0d", i), 32'(q0[i].d), 32'(exp_d[i]));
         chk($sformatf("adj_err_%0d", i), 32'(q0[i].e), 32'(exp_e[i]));
      end
      chk("adj_err_count", 32'(ec0), 1);
      send(1'b0, 4'b0000); send(1'b1, 4'b1111);
      idle();
      wait_out(6);
      chk("clr_b2g_data", 32'(q0[4].d), 0);
      chk("clr_g2b_data", 32'(q0[5].d), 'hA);
      chk("clr_g2b_err", 32'(q0[5].e), 0);
      chk("clr_err_count", 32'(ec0), 1);

      // Backpressure: 5 stalled cycles while streaming 1..6
      do_reset();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 6; i++) send(1'b0, 4'(i));
            idle();
         end
         begin
            for (int k = 1; k <= 5; k++) begin
               @(negedge clk); #2;
               if (k >= 3) begin
                  chk($sformatf("bp_in_ready_%0d", k), 32'(ir0), 0);
                  chk($sformatf("bp_out_valid_%0d", k), 32'(ov0), 1);
                  chk($sformatf("bp_out_data_%0d", k), 32'(od0), 1);
               end
            end
            #1 out_ready = 1'b1;
         end
      join
      wait_out(6);
      exp_d = '{1, 3, 2, 6, 7, 5};
      for (int i = 0; i < 6; i++) chk($sformatf("bp_order_%0d", i), 32'(q0[i].d), 32'(exp_d[i]));
      repeat (8) @(negedge clk);
      chk("bp_no_dup", 32'(q0.size()), 6);

      // Reset with two words in flight
      do_reset();
      send(1'b0, 4'h1); send(1'b0, 4'h2);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      #1;
      chk("rst_cycle_in_ready", 32'(ir0), 0);
      chk("rst_cycle_out_valid", 32'(ov0), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_out_valid", 32'(ov0), 0);
      chk("post_rst_err_count", 32'(ec0), 0);
      repeat (8) @(negedge clk);
      chk("no_stale_word", 32'(q0.size()), 0);

      // Five adjacency errors: 2-bit counter saturates
      do_reset();
      send(1'b1, 4'b0000);
      for (int i = 0; i < 5; i++) send(1'b1, (i % 2 == 0) ? 4'b0011 : 4'b0000);
      idle();
      wait_out(6);
      chk("sat_err_count_w2", 32'(ec4), 3);
      chk("err_count_s2", 32'(ec0), 5);
      chk("err_count_s1", 32'(ec1), 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gray_stream_converter.md
Name: gray_stream_converter

Overview:
- Parametrised, pipelined binary/Gray code converter with a valid/ready stream interface.
- Each transfer selects its direction: binary->Gray or Gray->binary.
- In Gray->binary mode it checks that successive Gray inputs are adjacent (Hamming distance <= 1) and flags violations. Intended for checking CDC pointer streams.
- Sits between a producer and consumer on one clock domain; throughput of one word per cycle.

Parameters:
- WIDTH, 8, data width in bits (>= 2).
- STAGES, 2, pipeline depth and fixed latency in cycles (1..4). The Gray->binary prefix-XOR is split across the stages.
- ERR_CNT_W, 16, width of the saturating adjacency-error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  converter can accept an input word.
- in_data  input  WIDTH  input word.
- in_mode  input  1  0 = binary->Gray, 1 = Gray->binary.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the output word.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  in_mode carried with the word.
- out_adj_err  output  1  adjacency violation for this word; only meaningful when out_mode = 1.
- err_count  output  ERR_CNT_W  saturating count of adjacency violations.

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - All stage valid bits = 0, so out_valid = 0.
  - out_data = 0, out_mode = 0, out_adj_err = 0, err_count = 0.
  - Adjacency history is marked invalid.
- Handshakes:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - A stage may load when it is empty or its contents advance this cycle. in_ready is stage 0 load-enable; the combinational ready chain is permitted.
  - While in_valid = 1 and in_ready = 0, in_data and in_mode must be held stable (producer rule; the bench asserts it).
  - While out_valid = 1 and out_ready = 0, out_data, out_mode and out_adj_err hold stable. No word is dropped or duplicated.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready is held at 1.
- Full throughput: with out_ready = 1 continuously, in_ready = 1 every cycle.
- Arithmetic:
  - Binary->Gray: g[i] = b[i] ^ b[i+1], g[WIDTH-1] = b[WIDTH-1].
  - Gray->binary: b[WIDTH-1] = g[WIDTH-1], b[i] = b[i+1] ^ g[i].
  - Bit groups are resolved MSB-first across the stages.
  - Results do not depend on STAGES.
- Adjacency check, evaluated in stage 0 at input transfer:
  - Holds prev_gray and a prev_vld flag.
  - On a mode-1 transfer with prev_vld = 1: err = popcount(in_data ^ prev_gray) > 1. A distance of 0 (repeat) is legal. The error travels with the word.
  - On a mode-1 transfer: prev_gray <= in_data, prev_vld <= 1.
  - On a mode-0 transfer: prev_vld <= 0. The next Gray word is therefore unchecked; the same applies after reset.
  - Mode-0 words always carry err = 0.
- err_count increments by 1 when a word with err = 1 transfers out. It saturates at all-ones.
- Mixed-mode streams are allowed back-to-back with no bubble.
- Reset mid-operation: all in-flight words are discarded, no output transfer occurs in the reset cycle, and in_ready = 0 during the reset cycle.

Decomposition:
- Package gray_stream_pkg holds:
  - mode constants MODE_B2G = 1'b0 and MODE_G2B = 1'b1;
  - a stage-payload struct {data, mode, err, partial};
  - functions bin2gray and popcount.
- Sub-module gray_pipe_stage (one pipeline register with valid/ready and partial prefix-XOR for its bit slice) is instantiated STAGES times by a generate loop.

Test Plan:
All scenarios use WIDTH = 4 and STAGES = 2 unless noted.
1. Mode 0, in_data = 4'b1011, out_ready = 1 -> out_data = 4'b1110, out_mode = 0, out_adj_err = 0, out_valid exactly 2 cycles after the transfer.
2. Mode 1, in_data = 4'b1110 -> out_data = 4'b1011. Sweep all 16 values in both modes at full rate: round-trip equality, in_ready constantly 1.
3. Mode 1 sequence 0011, 0010, 0110, 0101:
   - out_adj_err = 0, 0, 0, 1;
   - err_count = 1 after the last word transfers.
   - Then send mode 0 with 0000 followed by mode 1 with 1111 -> no error (history cleared).
4. Backpressure: out_ready = 0 for 5 cycles while streaming 1..6 in mode 0:
   - in_ready drops after the pipeline fills (2 words held);
   - out_data stays stable;
   - after release, the outputs are 0001, 0011, 0010, 0110, 0111, 0101 in order, with none lost.
5. Reset asserted 1 cycle while 2 words are in flight -> out_valid = 0 the next cycle, err_count = 0, and no stale word ever emerges.
6. With ERR_CNT_W = 2, force 5 adjacency errors -> err_count saturates at 3. Repeat scenario 2 with STAGES = 1 and STAGES = 4 -> identical data, latency 1 and 4.
